// File: rtl/down_counter_pkg.sv
// Shared types and reset constants for the down counter / timer.
package down_counter_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } state_t;

  // Every count bit resets to this value, so reset lands on all ones at any WIDTH.
  localparam logic COUNT_RST_BIT = 1'b1;
  localparam int   PRESCALE_RST  = 0;

endpackage

// File: rtl/down_counter_prescaler.sv
// Divides enable cycles by PRESCALE; tick is high on the enable cycle that wraps the divider.
module down_counter_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic tick
);
  import down_counter_pkg::*;

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] PS_RST  = PW'(PRESCALE_RST);

  logic [PW-1:0] ps_q;

  assign tick = en && (ps_q == PS_LAST);

  always_ff @(posedge clk) begin
    if (!rst || clear) ps_q <= PS_RST;
    else if (en)       ps_q <= (ps_q == PS_LAST) ? PS_RST : ps_q + 1'b1;
  end

endmodule

// File: rtl/down_counter.sv
// Loadable, enable-gated down counter / timer with auto-reload or one-shot halt.
// Define DOWN_COUNTER_PRESCALE_EN to divide enable cycles by PRESCALE per tick.
module down_counter #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy
);
  import down_counter_pkg::*;

  if (PRESCALE < 2) begin : g_bad_prescale
    $error("down_counter: PRESCALE must be >= 2");
  end

  state_t           state;
  logic [WIDTH-1:0] reload_q;
  logic             tick;

`ifdef DOWN_COUNTER_PRESCALE_EN
  // The divider only advances while running, so DONE freezes its phase.
  down_counter_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .en    (en && (state == RUN)),
    .clear (load),
    .tick  (tick)
  );
`else
  assign tick = en;
`endif

  assign busy = (state == RUN);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count    <= {WIDTH{COUNT_RST_BIT}};
      reload_q <= {WIDTH{COUNT_RST_BIT}};
      state    <= RUN;
      tc       <= 1'b0;
    end else if (load) begin
      count    <= load_val;
      reload_q <= load_val;
      state    <= RUN;
      tc       <= 1'b0;
    end else if (tick && state == RUN) begin
      if (count != '0) begin
        count <= count - 1'b1;
        tc    <= (count == WIDTH'(1));
      end else begin
        // At zero: reload for periodic mode, otherwise park in DONE holding 0.
        tc <= 1'b0;
        if (auto_reload) count <= reload_q;
        else             state <= DONE;
      end
    end else begin
      tc <= 1'b0;
    end
  end

endmodule

// File: doc/down_counter.md
Name: down_counter

Overview:
- Loadable, enable-gated binary down counter/timer. It is the decrementing counterpart of the team's free-running up counter.
- Counts from a reload value down to zero and pulses a terminal-count flag on arrival.
- At zero it either auto-reloads (periodic timer) or halts (one-shot).
- Used as a timeout/period generator beside the up counter in the Counters library.

Parameters:
- WIDTH, 4, bit width of count, load_val and the internal reload register.
- PRESCALE, 4, enable cycles per decrement tick. Used only when DOWN_COUNTER_PRESCALE_EN is defined; must be >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-low (rst=0 resets on the next rising clk edge).
- en  input  1  count enable; one decrement opportunity per cycle when high.
- load  input  1  load strobe; count and reload register take load_val.
- load_val  input  WIDTH  value for load.
- auto_reload  input  1  1 = reload at zero, 0 = one-shot halt at zero.
- count  output  WIDTH  current count (registered).
- tc  output  1  terminal-count pulse, registered, 1 cycle wide.
- busy  output  1  1 while state is RUN.

Behaviour:
- Single clock domain; all outputs registered; reset is synchronous and active-low.
- Reset (rst=0 at an edge):
  - count = all ones (4'b1111); reload_q = all ones.
  - state = RUN; tc = 0; busy = 1; prescale count = 0.
- Priority per edge: reset > load > en-driven decrement/reload > hold.
- States: RUN and DONE. busy = (state==RUN).
- Load (load=1):
  - count = load_val; reload_q = load_val; state = RUN; tc = 0.
  - No decrement that cycle, regardless of en.
  - Legal in either state.
- RUN, en=1, count > 1: count = count - 1; tc = 0.
- RUN, en=1, count == 1: count = 0; tc = 1 in the same edge, so tc and count==0 appear together.
- RUN, en=1, count == 0:
  - auto_reload=1: count = reload_q, stay RUN, tc = 0.
  - auto_reload=0: state = DONE, count holds 0, tc = 0.
  - auto_reload is sampled only at this edge.
- Auto-reload period is reload_q+1 enabled cycles, with one tc per period.
- en=0: count, state and tc hold except that tc clears to 0. tc never stays high 2 cycles.
- DONE: count holds 0 and ignores en. Exits only via load or reset.
- Load value 0: count = 0 with no tc. The next enabled cycle is the at-zero case. With auto_reload=1 and reload_q=0, count stays 0 and tc never fires.
- Arithmetic is unsigned modulo 2^WIDTH. Underflow below 0 is impossible by construction.
- Reset mid-run overrides simultaneous load/en.

Optional Feature:
- Macro: DOWN_COUNTER_PRESCALE_EN.
- Defined:
  - An internal prescale counter (0..PRESCALE-1) advances on each en=1 cycle in RUN.
  - A decrement/reload/halt action occurs only on the en cycle where the prescaler is at PRESCALE-1; the prescaler then wraps to 0.
  - load and reset clear the prescaler; en=0 holds it.
  - The tc rules are unchanged, applied at tick edges.
- Undefined: every en=1 cycle is a tick. PRESCALE is ignored and no prescaler flops are built.

Decomposition:
- Package down_counter_pkg:
  - state typedef: RUN, DONE.
  - count reset constant: all-ones of WIDTH.
  - prescale reset constant: 0.
- One natural sub-module: down_counter_prescaler. It takes clk, rst, en, clear and outputs tick. It is instantiated only under DOWN_COUNTER_PRESCALE_EN; otherwise tick = en.

Test Plan:
- Reset: WIDTH=4, rst=0 for 2 edges, then rst=1, en=0 -> count=4'b1111, tc=0, busy=1, all holding.
- Free-run periodic: after reset, en=1, auto_reload=1 -> count 15,14,...,1,0,15,...; tc=1 only on the cycle count=0; tc period 16 cycles.
- One-shot: load=1, load_val=3, auto_reload=0, then en=1 -> 3,2,1,0 with tc=1 at 0; next edge busy=0; count stays 0 for 10+ cycles; tc stays 0.
- Load vs en collision: count=9, en=1 and load=1 with load_val=12 on the same edge -> count=12, not 11 or 8; next en edge gives 11.
- Enable gap: count=6, en=0 for 5 cycles -> count stays 6, tc=0; en=1 resumes with 5.
- Reset priority: count=5, rst=0 with load=1, load_val=2 -> count=15, busy=1, tc=0. With DOWN_COUNTER_PRESCALE_EN and PRESCALE=4: load 2, en=1 -> count changes at the 4th and 8th en edges, tc at the 8th.
